// File: rtl/pb_mbox_pkg.sv
// pb_mbox_pkg: shared status bit positions, irq FSM states and default port addresses for the mailbox
package pb_mbox_pkg;
  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_CNT_LSB = 3;
  localparam logic [7:0] DATA_PORT_DEF = 8'h01;
  localparam logic [7:0] STATUS_PORT_DEF = 8'h02;
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_PEND, IRQ_MASK} irq_t;
  // An accepted push always (re)arms the interrupt, even over a same-cycle ack.
  function automatic irq_t irq_next(irq_t s, logic push, logic ack, logic empty);
    return push ? IRQ_PEND :
           (s == IRQ_PEND && ack) ? IRQ_MASK :
           (s == IRQ_MASK && empty) ? IRQ_IDLE : s;
  endfunction
endpackage

// File: rtl/pb_mailbox_if.sv
// pb_mailbox_if: one kcpsm3 core's I/O port bundle toward the mailbox
//   master: core side (drives port_id, strobes, out_port, interrupt_ack)
//   slave:  mailbox side (drives in_port, interrupt)
interface pb_mailbox_if #(parameter int DATA_W = 8);
  logic [7:0] port_id;
  logic write_strobe;
  logic read_strobe;
  logic [DATA_W-1:0] out_port;
  logic [DATA_W-1:0] in_port;
  logic interrupt;
  logic interrupt_ack;
  modport master(output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
                 input in_port, interrupt);
  modport slave(input port_id, write_strobe, read_strobe, out_port, interrupt_ack,
                output in_port, interrupt);
endinterface

// File: rtl/pb_mbox_fifo.sv
// pb_mbox_fifo: first-word fall-through FIFO on distributed RAM
//   push/din write, pop consumes head, dout shows head combinationally,
//   count saturates at DEPTH; push on full is accepted only alongside a pop
module pb_mbox_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/pb_mailbox.sv
// pb_mailbox: bidirectional buffered mailbox between two kcpsm3 cores, one FIFO per direction
//   clk, reset (sync, active-high); a, b: pb_mailbox_if.slave per core
//   DATA_PORT write pushes to the peer, read pops own rx; STATUS_PORT read returns
//   {rx count, overflow, tx_full, rx_valid}; interrupt raised while rx holds unacked data
//   MBOX_OVERFLOW_FLAG_EN: enables the sticky per-core overflow status bit
module pb_mailbox
  import pb_mbox_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter logic [7:0] DATA_PORT = DATA_PORT_DEF,
  parameter logic [7:0] STATUS_PORT = STATUS_PORT_DEF
) (
  input logic clk,
  input logic reset,
  pb_mailbox_if.slave a,
  pb_mailbox_if.slave b
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic a_push, a_pop, b_push, b_pop, a_acc, b_acc;
  logic [DATA_W-1:0] ab_dout, ba_dout, a_st, b_st;
  logic [CW-1:0] ab_count, ba_count;
  logic ab_full, ab_empty, ba_full, ba_empty, a_ovf, b_ovf;
  irq_t a_irq, b_irq, a_irq_n, b_irq_n;
  assign a_push = a.write_strobe & (a.port_id == DATA_PORT);
  assign a_pop = a.read_strobe & (a.port_id == DATA_PORT);
  assign b_push = b.write_strobe & (b.port_id == DATA_PORT);
  assign b_pop = b.read_strobe & (b.port_id == DATA_PORT);
  // full implies non-empty, so a consumer pop always frees the slot
  assign a_acc = a_push & (~ab_full | b_pop);
  assign b_acc = b_push & (~ba_full | a_pop);
  pb_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ab (
    .clk, .reset, .push(a_push), .pop(b_pop), .din(a.out_port),
    .dout(ab_dout), .count(ab_count), .full(ab_full), .empty(ab_empty)
  );
  pb_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ba (
    .clk, .reset, .push(b_push), .pop(a_pop), .din(b.out_port),
    .dout(ba_dout), .count(ba_count), .full(ba_full), .empty(ba_empty)
  );
  assign a_irq_n = irq_next(a_irq, b_acc, a.interrupt_ack, ba_empty);
  assign b_irq_n = irq_next(b_irq, a_acc, b.interrupt_ack, ab_empty);
  always_ff @(posedge clk)
    if (reset) begin
      a_irq <= IRQ_IDLE;
      b_irq <= IRQ_IDLE;
      a.interrupt <= 1'b0;
      b.interrupt <= 1'b0;
    end else begin
      a_irq <= a_irq_n;
      b_irq <= b_irq_n;
      a.interrupt <= a_irq_n == IRQ_PEND;
      b.interrupt <= b_irq_n == IRQ_PEND;
    end
`ifdef MBOX_OVERFLOW_FLAG_EN
  // sticky until a status read; a drop in the same cycle keeps it set
  always_ff @(posedge clk)
    if (reset) begin
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
    end else begin
      a_ovf <= (a_push & ~a_acc) | (a_ovf & ~(a.read_strobe & (a.port_id == STATUS_PORT)));
      b_ovf <= (b_push & ~b_acc) | (b_ovf & ~(b.read_strobe & (b.port_id == STATUS_PORT)));
    end
`else
  assign a_ovf = 1'b0;
  assign b_ovf = 1'b0;
`endif
  always_comb begin
    a_st = '0;
    a_st[ST_RX_VALID] = ~ba_empty;
    a_st[ST_TX_FULL] = ab_full;
    a_st[ST_OVF] = a_ovf;
    a_st[ST_CNT_LSB +: CW] = ba_count;
    b_st = '0;
    b_st[ST_RX_VALID] = ~ab_empty;
    b_st[ST_TX_FULL] = ba_full;
    b_st[ST_OVF] = b_ovf;
    b_st[ST_CNT_LSB +: CW] = ab_count;
  end
  assign a.in_port = reset ? '0 :
                     (a.port_id == DATA_PORT) ? (ba_empty ? '0 : ba_dout) :
                     (a.port_id == STATUS_PORT) ? a_st : '0;
  assign b.in_port = reset ? '0 :
                     (b.port_id == DATA_PORT) ? (ab_empty ? '0 : ab_dout) :
                     (b.port_id == STATUS_PORT) ? b_st : '0;
endmodule
